mult_issue_ctrl: RTL and testbench

- Operand issue and result capture controller for the two-phase 64x64 compressor multiplier core.
- Accepts operand pairs on a valid/ready handshake. Registers and holds each pair across the core's two-phase partial-product schedule.
- Generates the core's phase-aligning reset. Samples the core's 128-bit sum at a fixed latency and queues it in a small result FIFO with downstream backpressure.
- Sits between the operand source and the core, and between the core and the product consumer.

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_issue_ctrl_if.sv | 30 +++
 rtl/mult_result_fifo.sv | 59 +++++
 rtl/mult_issue_ctrl.sv | 98 +++++++++
 tb/tb_mult_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the compressor multiplier slice.
// Phase encoding mirrors the core's internal half-select toggle.
package mult_pkg;

  localparam int MULT_W          = 64;
  localparam int PROD_W          = 2 * MULT_W;
  localparam int CAPTURE_LAT_DEF = 3;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_e;

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// Operand and result streams between source, controller and consumer.
// master = source/consumer side, slave = controller side.
interface mult_issue_ctrl_if
  import mult_pkg::*;
#(
  parameter int IN_WIDTH  = MULT_W,
  parameter int TAG_WIDTH = 4
);

  logic                   in_valid;
  logic                   in_ready;
  logic [IN_WIDTH-1:0]    in_a;
  logic [IN_WIDTH-1:0]    in_b;
  logic [TAG_WIDTH-1:0]   in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*IN_WIDTH-1:0]  out_data;
  logic [TAG_WIDTH-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/mult_result_fifo.sv
// Small synchronous result FIFO with occupancy count.
// Head entry is read combinationally from storage.
module mult_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             full;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  // Upstream credit accounting must never let a push land on a full queue.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst) !(push && full)
  );

endmodule

// File: rtl/mult_issue_ctrl.sv
// Operand issue / product capture controller for the two-phase
// 64x64 compressor multiplier core.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int IN_WIDTH    = MULT_W,
  parameter int TAG_WIDTH   = 4,
  parameter int CAPTURE_LAT = CAPTURE_LAT_DEF,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  mult_issue_ctrl_if.slave      bus,
  output logic                  core_rst,
  output logic [IN_WIDTH-1:0]   core_in0,
  output logic [IN_WIDTH-1:0]   core_in1,
  input  logic [2*IN_WIDTH-1:0] core_outp,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = 2 * IN_WIDTH;
  localparam int FW = PW + TAG_WIDTH;

  phase_e                 phase;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic [CAPTURE_LAT-1:0] pipe_v;
  logic [TAG_WIDTH-1:0]   pipe_tag [CAPTURE_LAT];
  logic [CW:0]            used;
  logic                   ready;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   fifo_empty;
  logic [FW-1:0]          head;

  // Credits cover both queued results and ops still in the capture pipe.
  assign used   = {1'b0, fifo_count} + {1'b0, inflight};
  assign ready  = !core_rst && (phase == PH_LO)
                && (used < (CW+1)'(FIFO_DEPTH));
  assign accept = bus.in_valid && ready;
  assign push   = pipe_v[CAPTURE_LAT-1];
  assign pop    = !fifo_empty && bus.out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_rst <= 1'b1;
      phase    <= PH_LO;
      core_in0 <= '0;
      core_in1 <= '0;
      inflight <= '0;
      pipe_v   <= '0;
      for (int i = 0; i < CAPTURE_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      core_rst <= 1'b0;
      if (core_rst)            phase <= PH_HI;
      else if (phase == PH_LO) phase <= PH_HI;
      else                     phase <= PH_LO;
      if (accept) begin
        core_in0 <= bus.in_a;
        core_in1 <= bus.in_b;
      end
      pipe_v[0]   <= accept;
      pipe_tag[0] <= bus.in_tag;
      for (int i = 1; i < CAPTURE_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      unique case ({accept, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  mult_result_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({core_outp, pipe_tag[CAPTURE_LAT-1]}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.in_ready  = ready;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : head[FW-1:TAG_WIDTH];
  assign bus.out_tag   = fifo_empty ? '0 : head[TAG_WIDTH-1:0];
  assign busy          = (inflight != '0) || !fifo_empty;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a two-phase core model.
// Core model: high-half partial in phase 0, low half + sum in phase 1.
module tb_mult_issue_ctrl;
  import mult_pkg::*;

  localparam int IW = 64;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_issue_ctrl_if #(.IN_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

  logic            core_rst;
  logic [IW-1:0]   core_in0;
  logic [IW-1:0]   core_in1;
  logic [2*IW-1:0] core_outp;
  logic            busy;

  mult_issue_ctrl #(
    .IN_WIDTH    (IW),
    .TAG_WIDTH   (TW),
    .CAPTURE_LAT (3),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .core_rst  (core_rst),
    .core_in0  (core_in0),
    .core_in1  (core_in1),
    .core_outp (core_outp),
    .busy      (busy)
  );

  logic        cph;
  logic [127:0] hi_pp;
  logic [127:0] core_sum;

  always @(posedge clk) begin
    if (core_rst) cph <= 1'b0;
    else          cph <= ~cph;
    if (cph == 1'b0)
      hi_pp <= 128'(core_in0[63:32]) * 128'(core_in1);
    else
      core_sum <= (hi_pp << 32) + 128'(core_in0[31:0]) * 128'(core_in1);
  end
  assign core_outp = core_sum;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [127:0] gd_q [$];
  logic [TW-1:0] gt_q [$];
  int acc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.out_valid && bus.out_ready) begin
        gd_q.push_back(bus.out_data);
        gt_q.push_back(bus.out_tag);
      end
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    gd_q.delete();
    gt_q.delete();
    acc_q.delete();
  endtask

  task automatic send(input logic [IW-1:0] a, input logic [IW-1:0] b,
                      input logic [TW-1:0] t);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        return;
      end
    end
    chk("send_tmo", 128'(bus.in_ready), 128'd1);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && gd_q.size() < n; i++) tick();
    chk("got_cnt", 128'(gd_q.size()), 128'(n));
  endtask

  task automatic chk_res(input int i, input logic [127:0] d,
                         input logic [TW-1:0] t);
    logic [127:0] gd;
    logic [TW-1:0] gt;
    gd = (i < gd_q.size()) ? gd_q[i] : 'x;
    gt = (i < gt_q.size()) ? gt_q[i] : 'x;
    chk($sformatf("res%0d_data", i), gd, d);
    chk($sformatf("res%0d_tag", i), 128'(gt), 128'(t));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    tick(3);

    chk("rst_core_rst",  128'(core_rst),      128'd1);
    chk("rst_core_in0",  128'(core_in0),      128'd0);
    chk("rst_core_in1",  128'(core_in1),      128'd0);
    chk("rst_in_ready",  128'(bus.in_ready),  128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data",  bus.out_data,        128'd0);
    chk("rst_out_tag",   128'(bus.out_tag),   128'd0);
    chk("rst_busy",      128'(busy),          128'd0);

    // Basic: 3 x 5, tag 1, offered before release
    bus.in_a     = 64'd3;
    bus.in_b     = 64'd5;
    bus.in_tag   = 4'd1;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_core_rst_hold", 128'(core_rst), 128'd1);
    tick();
    chk("rel_core_rst_low", 128'(core_rst), 128'd0);
    chk("ph0_in_ready", 128'(bus.in_ready), 128'd0);
    tick();
    chk("ph1_in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("basic_acc_cnt", 128'(acc_q.size()), 128'd1);
    chk("basic_in0", 128'(core_in0), 128'd3);
    chk("basic_in1", 128'(core_in1), 128'd5);
    chk("basic_busy", 128'(busy), 128'd1);
    tick(2);
    chk("basic_early_valid", 128'(bus.out_valid), 128'd0);
    tick();
    chk("basic_valid", 128'(bus.out_valid), 128'd1);
    chk("basic_data", bus.out_data, 128'd15);
    chk("basic_tag", 128'(bus.out_tag), 128'd1);
    tick();
    chk("basic_drain_valid", 128'(bus.out_valid), 128'd0);
    chk("basic_idle", 128'(busy), 128'd0);

    // Max operands
    clr();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hA);
    bus.in_valid = 1'b0;
    wait_got(1, 20);
    chk_res(0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 4'hA);

    // Streaming with out_ready high
    clr();
    send(64'd2, 64'd7, 4'd1);
    send(64'h1_0000_0000, 64'h1_0000_0000, 4'd2);
    send(64'd1, 64'd0, 4'd3);
    send(64'hDEAD_BEEF, 64'd2, 4'd4);
    bus.in_valid = 1'b0;
    wait_got(4, 40);
    chk("strm_acc_cnt", 128'(acc_q.size()), 128'd4);
    if (acc_q.size() >= 2)
      chk("strm_b2b_gap", 128'(acc_q[1] - acc_q[0]), 128'd2);
    chk_res(0, 128'd14, 4'd1);
    chk_res(1, 128'h1_0000_0000_0000_0000, 4'd2);
    chk_res(2, 128'd0, 4'd3);
    chk_res(3, 128'h1_BD5B_7DDE, 4'd4);

    // Backpressure: only two credits
    tick(4);
    clr();
    bus.out_ready = 1'b0;
    fork
      begin
        send(64'd6, 64'd7, 4'd5);
        send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'd6);
        send(64'd100, 64'd100, 4'd7);
        send(64'h8000_0000_0000_0000, 64'd2, 4'd8);
        bus.in_valid = 1'b0;
      end
      begin
        tick(14);
        chk("bp_acc_cnt", 128'(acc_q.size()), 128'd2);
        chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
        chk("bp_valid", 128'(bus.out_valid), 128'd1);
        chk("bp_head", bus.out_data, 128'd42);
        chk("bp_head_tag", 128'(bus.out_tag), 128'd5);
        tick();
        chk("bp_hold", bus.out_data, 128'd42);
        chk("bp_busy", 128'(busy), 128'd1);
        chk("bp_no_pop", 128'(gd_q.size()), 128'd0);
        bus.out_ready = 1'b1;
        wait_got(4, 80);
      end
    join
    chk("bp_acc_total", 128'(acc_q.size()), 128'd4);
    chk_res(0, 128'd42, 4'd5);
    chk_res(1, 128'hFFFF_FFFE_0000_0001, 4'd6);
    chk_res(2, 128'd10000, 4'd7);
    chk_res(3, 128'h1_0000_0000_0000_0000, 4'd8);

    // Phase gating: one-cycle pulse in phase 0
    tick(4);
    clr();
    for (int i = 0; i < 10 && !bus.in_ready; i++) tick();
    tick();
    bus.in_a     = 64'h55;
    bus.in_b     = 64'h66;
    bus.in_tag   = 4'hC;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(8);
    chk("gate_acc", 128'(acc_q.size()), 128'd0);
    chk("gate_in0", 128'(core_in0), 128'h8000_0000_0000_0000);
    chk("gate_in1", 128'(core_in1), 128'd2);
    chk("gate_no_res", 128'(gd_q.size()), 128'd0);
    chk("gate_idle", 128'(busy), 128'd0);

    // Reset one cycle after an accept
    send(64'h1234, 64'h10, 4'd9);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_core_rst", 128'(core_rst), 128'd1);
    chk("mid_in0", 128'(core_in0), 128'd0);
    chk("mid_in1", 128'(core_in1), 128'd0);
    chk("mid_in_ready", 128'(bus.in_ready), 128'd0);
    chk("mid_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_busy", 128'(busy), 128'd0);
    tick(3);
    rst = 1'b1;
    clr();
    @(negedge clk);
    chk("mid_rel_hold", 128'(core_rst), 128'd1);
    tick();
    chk("mid_rel_low", 128'(core_rst), 128'd0);
    tick(8);
    chk("mid_no_stale", 128'(gd_q.size()), 128'd0);
    chk("mid_idle", 128'(busy), 128'd0);
    send(64'd9, 64'd9, 4'd3);
    bus.in_valid = 1'b0;
    wait_got(1, 20);
    chk_res(0, 128'd81, 4'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
